// File: rtl/inst_memory.sv
// rtl/inst_memory.sv - instruction memory with async fetch port and byte-stream image loader
module inst_memory #(
    parameter int          ADDR_BITS = 8,
    parameter logic [31:0] BASE_ADRS = 32'h0000_0000
) (
    input  logic        clk_cpu,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] inst,
    output logic        pc_fault,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    output logic        cpu_hold,
    output logic        ld_overflow
);
    localparam int          DEPTH = 1 << ADDR_BITS;
    localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

    typedef enum logic [2:0] {RUN, LEN_HI, LEN_LO, DATA, RELEASE} state_t;

    state_t      state;
    logic [31:0] mem [DEPTH];
    logic [15:0] len;
    logic [15:0] word_cnt;
    logic [1:0]  byte_cnt;
    logic [23:0] shift;
    logic        accept;
    logic        word_done;
    logic        in_range;
    logic        wr_en;
    logic [31:0] offset;

    assign accept    = ld_valid && ld_ready;
    assign word_done = accept && (state == DATA) && (byte_cnt == 2'd3);
    assign in_range  = {16'b0, word_cnt} < 32'(DEPTH);
    // A reset landing on the 4th byte discards the word rather than committing it.
    assign wr_en     = word_done && in_range && !reset;

    always_ff @(posedge clk_cpu) begin
        if (wr_en) begin
            mem[word_cnt[ADDR_BITS-1:0]] <= {shift, ld_data};
        end
    end

    assign offset   = pc - BASE_ADRS;
    assign pc_fault = (pc[1:0] != 2'b00) || ({1'b0, offset} >= SPAN);
    assign inst     = (!pc_fault && state == RUN) ? mem[offset[ADDR_BITS+1:2]] : 32'h0000_0000;

    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            state       <= RUN;
            cpu_hold    <= 1'b0;
            ld_ready    <= 1'b0;
            ld_overflow <= 1'b0;
            len         <= 16'd0;
            word_cnt    <= 16'd0;
            byte_cnt    <= 2'd0;
            shift       <= 24'd0;
        end else begin
            case (state)
                RUN: begin
                    if (ld_start) begin
                        state       <= LEN_HI;
                        cpu_hold    <= 1'b1;
                        ld_ready    <= 1'b1;
                        ld_overflow <= 1'b0;
                        word_cnt    <= 16'd0;
                        byte_cnt    <= 2'd0;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        len[15:8] <= ld_data;
                        state     <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len[7:0] <= ld_data;
                        if ({len[15:8], ld_data} == 16'd0) begin
                            state    <= RELEASE;
                            ld_ready <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        shift    <= {shift[15:0], ld_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            word_cnt <= word_cnt + 16'd1;
                            if (!in_range) begin
                                ld_overflow <= 1'b1;
                            end
                            if (word_cnt + 16'd1 == len) begin
                                state    <= RELEASE;
                                ld_ready <= 1'b0;
                            end
                        end
                    end
                end
                RELEASE: begin
                    state    <= RUN;
                    cpu_hold <= 1'b0;
                end
                default: begin
                    state    <= RUN;
                    cpu_hold <= 1'b0;
                    ld_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_inst_memory.sv
// tb/tb_inst_memory.sv - self-checking bench for inst_memory (default depth and a 4-word instance)
module tb_inst_memory;
    localparam logic [31:0] SBASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = 32'd2;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = 8'd0;

    logic [31:0] inst_b, inst_s;
    logic        fault_b, fault_s, rdy, rdy_s, hold, hold_s, ovf_b, ovf_s;

    int total = 0;
    int bad = 0;

    logic [31:0] mb [256];
    bit          kb [256];
    logic [31:0] ms [4];
    bit          ks [4];
    logic [31:0] img [$];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } vec_t;
    vec_t tbl [6];

    inst_memory dut (
        .clk_cpu(clk), .reset(reset), .pc(pc), .inst(inst_b), .pc_fault(fault_b),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(rdy), .cpu_hold(hold), .ld_overflow(ovf_b)
    );

    inst_memory #(.ADDR_BITS(2), .BASE_ADRS(SBASE)) dut_s (
        .clk_cpu(clk), .reset(reset), .pc(pc), .inst(inst_s), .pc_fault(fault_s),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(rdy_s), .cpu_hold(hold_s), .ld_overflow(ovf_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic st);
        int n = 0;
        ld_valid = 1'b1;
        ld_data  = b;
        ld_start = st;
        while (!rdy && n < 50) begin
            tick();
            n++;
        end
        if (!rdy) chk("ready_timeout", rdy, 1);
        tick();
        ld_valid = 1'b0;
        ld_start = 1'b0;
    endtask

    // Sends img as a full image; length-high byte is offered together with ld_start.
    task automatic do_load(input int gap, input int start_at);
        logic [15:0] n;
        logic [7:0]  q [$];
        logic [31:0] w;
        n = 16'(img.size());
        q.push_back(n[15:8]);
        q.push_back(n[7:0]);
        foreach (img[k]) begin
            w = img[k];
            for (int s = 3; s >= 0; s--) q.push_back(w[8*s +: 8]);
        end
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_data  = q[0];
        tick();
        ld_start = 1'b0;
        chk("hold_after_start", hold, 1);
        chk("hold_s_after_start", hold_s, 1);
        chk("ready_after_start", rdy, 1);
        chk("ovf_b_cleared", ovf_b, 0);
        chk("ovf_s_cleared", ovf_s, 0);
        foreach (q[i]) begin
            send_byte(q[i], i == start_at);
            if (gap > 0 && i != q.size() - 1) repeat (gap) tick();
        end
        chk("hold_in_release", hold, 1);
        chk("ready_in_release", rdy, 0);
        tick();
        chk("hold_after_release", hold, 0);
        chk("hold_s_after_release", hold_s, 0);
        foreach (img[k]) begin
            if (k < 256) begin mb[k] = img[k]; kb[k] = 1'b1; end
            if (k < 4)   begin ms[k] = img[k]; ks[k] = 1'b1; end
        end
        chk("ovf_b", ovf_b, 32'(n > 16'd256));
        chk("ovf_s", ovf_s, 32'(n > 16'd4));
    endtask

    task automatic check_read(input logic [31:0] a);
        logic [31:0] off;
        logic        f;
        pc = a;
        #1;
        f = (a % 4 != 0) || (a >= 32'd1024);
        chk("fault_b", fault_b, 32'(f));
        if (f) chk("inst_b_nop", inst_b, 0);
        else if (kb[a / 4]) chk("inst_b", inst_b, mb[a / 4]);
        off = a - SBASE;
        f = (a % 4 != 0) || (off >= 32'd16);
        chk("fault_s", fault_s, 32'(f));
        if (f) chk("inst_s_nop", inst_s, 0);
        else if (ks[off / 4]) chk("inst_s", inst_s, ms[off / 4]);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'd0,    32'hDEAD_BEEF, 1'b0};
        tbl[1] = '{32'd4,    32'h0123_4567, 1'b0};
        tbl[2] = '{32'd2,    32'h0,         1'b1};
        tbl[3] = '{32'd1024, 32'h0,         1'b1};
        tbl[4] = '{32'd1,    32'h0,         1'b1};
        tbl[5] = '{32'd3,    32'h0,         1'b1};

        repeat (2) tick();
        chk("rst_hold", hold, 0);
        chk("rst_hold_s", hold_s, 0);
        chk("rst_ready", rdy, 0);
        chk("rst_ovf_b", ovf_b, 0);
        chk("rst_ovf_s", ovf_s, 0);
        chk("rst_fault_pc2", fault_b, 1);
        chk("rst_inst_pc2", inst_b, 0);
        reset = 1'b0;
        tick();

        img = '{32'hDEAD_BEEF, 32'h0123_4567};
        do_load(0, -1);
        foreach (tbl[i]) begin
            pc = tbl[i].pc;
            #1;
            chk($sformatf("tbl_inst_%0d", i), inst_b, tbl[i].inst);
            chk($sformatf("tbl_fault_%0d", i), fault_b, 32'(tbl[i].fault));
        end

        img = {};
        do_load(0, -1);
        check_read(0);
        check_read(4);
        check_read(SBASE);

        img = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h5555_5555};
        do_load(0, -1);
        for (int a = 0; a < 24; a += 4) check_read(SBASE + 32'(a));
        check_read(16);
        check_read(SBASE - 4);

        img = '{32'hAABB_CCDD};
        do_load(1, -1);
        check_read(0);
        check_read(SBASE);

        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h99, 1'b0);
        send_byte(8'h88, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_hold", hold, 0);
        chk("midrst_ready", rdy, 0);
        chk("midrst_ready_s", rdy_s, 0);
        check_read(0);
        check_read(SBASE);
        tick();

        img = '{32'hCAFE_F00D, 32'h1234_5678, 32'h0BAD_C0DE};
        do_load(0, 7);
        for (int a = 0; a < 12; a += 4) begin
            check_read(32'(a));
            check_read(SBASE + 32'(a));
        end

        img = {};
        for (int k = 0; k < 256; k++) img.push_back((32'(k) * 32'h0100_0193) ^ 32'hA5A5_0000);
        do_load(0, -1);
        check_read(1020);
        check_read(1024);
        check_read(0);
        check_read(SBASE + 12);

        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 6);
            img = {};
            for (int k = 0; k < n; k++) img.push_back($urandom);
            do_load($urandom_range(0, 2), $urandom_range(0, 4 * n + 1));
            for (int j = 0; j < 25; j++) begin
                case ($urandom_range(0, 2))
                    0:       check_read(32'($urandom_range(0, 1100)));
                    1:       check_read(SBASE - 8 + 32'($urandom_range(0, 40)));
                    default: check_read($urandom);
                endcase
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
